// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants the SDRAM controller to SPI (priority) or user, with a grant watchdog
module sdram_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  spi_critical,
   input  logic                  spi_refresh_inhibit,
   input  logic                  spi_req,
   input  logic [ADDR_WIDTH-1:0] spi_addr,
   output logic                  spi_ack,
   input  logic                  user_req,
   input  logic                  user_we,
   input  logic [ADDR_WIDTH-1:0] user_addr,
   input  logic [DATA_WIDTH-1:0] user_wr_data,
   input  logic [1:0]            user_wr_mask,
   output logic                  user_ack,
   output logic                  user_idle,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  sd_enable,
   output logic                  sd_we,
   output logic [ADDR_WIDTH-1:0] sd_addr,
   output logic [DATA_WIDTH-1:0] sd_wr_data,
   output logic [1:0]            sd_wr_mask,
   input  logic [DATA_WIDTH-1:0] sd_rd_data,
   input  logic                  sd_ack_level,
   input  logic                  sd_idle,
   output logic                  sd_refresh_inhibit,
   output logic                  owner_spi,
   output logic [7:0]            timeout_count
);
   typedef enum logic [1:0] {IDLE, SPI_ACC, USER_ACC, RELEASE} state_t;
   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);
   state_t                state_q, state_d;
   logic [7:0]            wd_q, wd_d, timeout_count_q, timeout_count_d;
   logic                  sd_enable_q, sd_enable_d, sd_we_q, sd_we_d;
   logic [ADDR_WIDTH-1:0] sd_addr_q, sd_addr_d;
   logic [DATA_WIDTH-1:0] sd_wr_data_q, sd_wr_data_d, rd_data_q, rd_data_d;
   logic [1:0]            sd_wr_mask_q, sd_wr_mask_d;
   logic                  spi_ack_q, spi_ack_d, user_ack_q, user_ack_d;
   logic                  owner_spi_q, owner_spi_d, ref_inh_q, ref_inh_d;
   always_comb begin
      state_d         = state_q;
      wd_d            = wd_q;
      timeout_count_d = timeout_count_q;
      sd_enable_d     = sd_enable_q;
      sd_we_d         = sd_we_q;
      sd_addr_d       = sd_addr_q;
      sd_wr_data_d    = sd_wr_data_q;
      sd_wr_mask_d    = sd_wr_mask_q;
      rd_data_d       = rd_data_q;
      spi_ack_d       = 1'b0;
      user_ack_d      = 1'b0;
      owner_spi_d     = owner_spi_q;
      ref_inh_d       = spi_critical && spi_refresh_inhibit;
      case (state_q)
         IDLE: begin
            if (spi_req) begin
               state_d      = SPI_ACC;
               wd_d         = 8'd0;
               sd_enable_d  = 1'b1;
               sd_we_d      = 1'b0;
               sd_addr_d    = spi_addr;
               sd_wr_data_d = DATA_WIDTH'(16'hDEAD);
               sd_wr_mask_d = 2'b00;
               owner_spi_d  = 1'b1;
            end else if (user_req && !spi_critical) begin
               state_d      = USER_ACC;
               wd_d         = 8'd0;
               sd_enable_d  = 1'b1;
               sd_we_d      = user_we;
               sd_addr_d    = user_addr;
               sd_wr_data_d = user_wr_data;
               sd_wr_mask_d = user_wr_mask;
               owner_spi_d  = 1'b0;
            end
         end
         SPI_ACC, USER_ACC: begin
            wd_d = wd_q + 8'd1;
            if (sd_ack_level) begin
               state_d     = RELEASE;
               sd_enable_d = 1'b0;
               rd_data_d   = sd_rd_data;
               spi_ack_d   = state_q == SPI_ACC;
               user_ack_d  = state_q == USER_ACC;
            end else if (wd_q == WD_LIMIT) begin
               state_d         = RELEASE;
               sd_enable_d     = 1'b0;
               timeout_count_d = (timeout_count_q == 8'hFF) ? timeout_count_q : timeout_count_q + 8'd1;
            end
         end
         RELEASE: state_d = sd_ack_level ? RELEASE : IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         wd_q            <= '0;
         timeout_count_q <= '0;
         sd_enable_q     <= 1'b0;
         sd_we_q         <= 1'b0;
         sd_addr_q       <= '0;
         sd_wr_data_q    <= '0;
         sd_wr_mask_q    <= '0;
         rd_data_q       <= '0;
         spi_ack_q       <= 1'b0;
         user_ack_q      <= 1'b0;
         owner_spi_q     <= 1'b0;
         ref_inh_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         wd_q            <= wd_d;
         timeout_count_q <= timeout_count_d;
         sd_enable_q     <= sd_enable_d;
         sd_we_q         <= sd_we_d;
         sd_addr_q       <= sd_addr_d;
         sd_wr_data_q    <= sd_wr_data_d;
         sd_wr_mask_q    <= sd_wr_mask_d;
         rd_data_q       <= rd_data_d;
         spi_ack_q       <= spi_ack_d;
         user_ack_q      <= user_ack_d;
         owner_spi_q     <= owner_spi_d;
         ref_inh_q       <= ref_inh_d;
      end
   end
   assign spi_ack            = spi_ack_q;
   assign user_ack           = user_ack_q;
   assign user_idle          = sd_idle && !spi_critical && state_q == IDLE;
   assign rd_data            = rd_data_q;
   assign sd_enable          = sd_enable_q;
   assign sd_we              = sd_we_q;
   assign sd_addr            = sd_addr_q;
   assign sd_wr_data         = sd_wr_data_q;
   assign sd_wr_mask         = sd_wr_mask_q;
   assign sd_refresh_inhibit = ref_inh_q;
   assign owner_spi          = owner_spi_q;
   assign timeout_count      = timeout_count_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed checks of arbitration, ack timing, watchdog and reset
module tb_sdram_arbiter;
   localparam int AW = 32;
   localparam int DW = 16;
   localparam int TO = 20;
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          spi_critical = 1'b0, spi_refresh_inhibit = 1'b0, spi_req = 1'b0;
   logic [AW-1:0] spi_addr = '0;
   logic          spi_ack;
   logic          user_req = 1'b0, user_we = 1'b0;
   logic [AW-1:0] user_addr = '0;
   logic [DW-1:0] user_wr_data = '0;
   logic [1:0]    user_wr_mask = '0;
   logic          user_ack, user_idle;
   logic [DW-1:0] rd_data;
   logic          sd_enable, sd_we;
   logic [AW-1:0] sd_addr;
   logic [DW-1:0] sd_wr_data;
   logic [1:0]    sd_wr_mask;
   logic [DW-1:0] sd_rd_data = '0;
   logic          sd_ack_level = 1'b0, sd_idle = 1'b1;
   logic          sd_refresh_inhibit, owner_spi;
   logic [7:0]    timeout_count;
   int            checks = 0;
   int            errors = 0;
   sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .spi_critical(spi_critical), .spi_refresh_inhibit(spi_refresh_inhibit),
      .spi_req(spi_req), .spi_addr(spi_addr), .spi_ack(spi_ack),
      .user_req(user_req), .user_we(user_we), .user_addr(user_addr),
      .user_wr_data(user_wr_data), .user_wr_mask(user_wr_mask),
      .user_ack(user_ack), .user_idle(user_idle), .rd_data(rd_data),
      .sd_enable(sd_enable), .sd_we(sd_we), .sd_addr(sd_addr),
      .sd_wr_data(sd_wr_data), .sd_wr_mask(sd_wr_mask), .sd_rd_data(sd_rd_data),
      .sd_ack_level(sd_ack_level), .sd_idle(sd_idle),
      .sd_refresh_inhibit(sd_refresh_inhibit), .owner_spi(owner_spi),
      .timeout_count(timeout_count)
   );
   always #5 clk = ~clk;
   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      reset = 1'b1;
      step();
      step();
      checks++; if ({sd_enable, sd_we, sd_wr_mask, spi_ack, user_ack, owner_spi, sd_refresh_inhibit} !== 9'b0) begin errors++; $display("FAIL reset_ctrl: got %b exp 0", {sd_enable, sd_we, sd_wr_mask, spi_ack, user_ack, owner_spi, sd_refresh_inhibit}); end
      checks++; if ({sd_addr, sd_wr_data, rd_data, timeout_count} !== '0) begin errors++; $display("FAIL reset_data: addr %h wdata %h rdata %h tcnt %h exp 0", sd_addr, sd_wr_data, rd_data, timeout_count); end
      checks++; if (user_idle !== 1'b1) begin errors++; $display("FAIL reset_user_idle: got %b exp 1", user_idle); end
      reset = 1'b0;
      step();
   endtask
   task automatic test_user_write;
      int acks = 0;
      user_req = 1'b1; user_we = 1'b1; user_addr = 32'h100; user_wr_data = 16'h1234; user_wr_mask = 2'b11;
      step();
      checks++; if ({sd_enable, sd_we, sd_wr_mask, owner_spi} !== 5'b11110) begin errors++; $display("FAIL uw_ctrl: got %b exp 11110", {sd_enable, sd_we, sd_wr_mask, owner_spi}); end
      checks++; if (sd_addr !== 32'h100 || sd_wr_data !== 16'h1234) begin errors++; $display("FAIL uw_addr_data: got %h/%h exp 00000100/1234", sd_addr, sd_wr_data); end
      checks++; if (user_idle !== 1'b0) begin errors++; $display("FAIL uw_busy_idle: got %b exp 0", user_idle); end
      step();
      step();
      sd_ack_level = 1'b1; sd_rd_data = 16'hBEEF;
      step();
      checks++; if (user_ack !== 1'b1 || sd_enable !== 1'b0) begin errors++; $display("FAIL uw_ack_timing: ack %b en %b exp 1 0", user_ack, sd_enable); end
      acks += int'(user_ack);
      user_req = 1'b0;
      step(); acks += int'(user_ack);
      step(); acks += int'(user_ack);
      sd_ack_level = 1'b0;
      step(); acks += int'(user_ack);
      checks++; if (acks != 1) begin errors++; $display("FAIL uw_ack_count: got %0d exp 1", acks); end
      checks++; if (user_idle !== 1'b1 || rd_data !== 16'hBEEF) begin errors++; $display("FAIL uw_return_idle: idle %b rd %h exp 1 beef", user_idle, rd_data); end
   endtask
   task automatic test_spi_priority;
      int bad = 0;
      spi_critical = 1'b1; spi_refresh_inhibit = 1'b1;
      spi_req = 1'b1; spi_addr = 32'h0000_0040;
      user_req = 1'b1; user_we = 1'b1; user_addr = 32'h300; user_wr_data = 16'h5555; user_wr_mask = 2'b01;
      step();
      checks++; if ({sd_enable, sd_we, sd_wr_mask, owner_spi} !== 5'b10001) begin errors++; $display("FAIL sp_ctrl: got %b exp 10001", {sd_enable, sd_we, sd_wr_mask, owner_spi}); end
      checks++; if (sd_wr_data !== 16'hDEAD || sd_addr !== 32'h40) begin errors++; $display("FAIL sp_data: got %h/%h exp dead/00000040", sd_wr_data, sd_addr); end
      checks++; if (sd_refresh_inhibit !== 1'b1 || user_idle !== 1'b0) begin errors++; $display("FAIL sp_refinh: inh %b idle %b exp 1 0", sd_refresh_inhibit, user_idle); end
      sd_ack_level = 1'b1; sd_rd_data = 16'h00A5;
      step();
      checks++; if (spi_ack !== 1'b1 || user_ack !== 1'b0 || rd_data !== 16'h00A5) begin errors++; $display("FAIL sp_ack: spi %b user %b rd %h exp 1 0 00a5", spi_ack, user_ack, rd_data); end
      spi_req = 1'b0;
      for (int i = 0; i < 3; i++) begin step(); bad += int'(spi_ack); end
      checks++; if (bad != 0) begin errors++; $display("FAIL sp_no_repeat: got %0d extra acks exp 0", bad); end
      sd_ack_level = 1'b0;
      step();
      bad = 0;
      for (int i = 0; i < 6; i++) begin step(); bad += int'(sd_enable) + int'(user_ack); end
      checks++; if (bad != 0) begin errors++; $display("FAIL sp_user_locked: got %0d grants exp 0", bad); end
      spi_critical = 1'b0;
      step();
      checks++; if ({sd_enable, owner_spi, sd_we, sd_refresh_inhibit} !== 4'b1010 || sd_addr !== 32'h300) begin errors++; $display("FAIL sp_user_after: got %b addr %h exp 1010 00000300", {sd_enable, owner_spi, sd_we, sd_refresh_inhibit}, sd_addr); end
      sd_ack_level = 1'b1;
      step();
      checks++; if (user_ack !== 1'b1) begin errors++; $display("FAIL sp_user_ack: got %b exp 1", user_ack); end
      user_req = 1'b0; sd_ack_level = 1'b0; spi_refresh_inhibit = 1'b0;
      step();
   endtask
   task automatic test_critical_mid_user;
      user_req = 1'b1; user_we = 1'b0; user_addr = 32'h200;
      step();
      spi_critical = 1'b1; spi_req = 1'b1; spi_addr = 32'h10;
      step();
      checks++; if (sd_enable !== 1'b1 || owner_spi !== 1'b0) begin errors++; $display("FAIL cm_inflight: en %b owner %b exp 1 0", sd_enable, owner_spi); end
      sd_ack_level = 1'b1;
      step();
      checks++; if (user_ack !== 1'b1 || spi_ack !== 1'b0) begin errors++; $display("FAIL cm_user_ack: user %b spi %b exp 1 0", user_ack, spi_ack); end
      user_req = 1'b0; sd_ack_level = 1'b0;
      step();
      step();
      checks++; if (sd_enable !== 1'b1 || owner_spi !== 1'b1 || sd_addr !== 32'h10 || sd_we !== 1'b0) begin errors++; $display("FAIL cm_spi_grant: en %b owner %b addr %h we %b exp 1 1 00000010 0", sd_enable, owner_spi, sd_addr, sd_we); end
      sd_ack_level = 1'b1;
      step();
      checks++; if (spi_ack !== 1'b1) begin errors++; $display("FAIL cm_spi_ack: got %b exp 1", spi_ack); end
      spi_req = 1'b0; sd_ack_level = 1'b0; spi_critical = 1'b0;
      step();
   endtask
   task automatic test_timeout;
      int cyc = 0, acks = 0, expiries = 1, guard = 0;
      logic prev_en;
      user_req = 1'b1; user_we = 1'b1; user_addr = 32'h400;
      step();
      while (sd_enable && cyc < 100) begin
         cyc++;
         acks += int'(user_ack);
         step();
      end
      checks++; if (cyc != TO) begin errors++; $display("FAIL to_enable_cycles: got %0d exp %0d", cyc, TO); end
      checks++; if (timeout_count !== 8'd1) begin errors++; $display("FAIL to_count1: got %0d exp 1", timeout_count); end
      prev_en = sd_enable;
      while (expiries < 300 && guard < 20000) begin
         step();
         guard++;
         acks += int'(user_ack);
         if (prev_en && !sd_enable) expiries++;
         prev_en = sd_enable;
      end
      checks++; if (expiries != 300) begin errors++; $display("FAIL to_expiry_budget: got %0d expiries exp 300", expiries); end
      checks++; if (timeout_count !== 8'd255) begin errors++; $display("FAIL to_saturate: got %0d exp 255", timeout_count); end
      checks++; if (acks != 0) begin errors++; $display("FAIL to_no_ack: got %0d acks exp 0", acks); end
      user_req = 1'b0;
      for (int i = 0; i < TO + 5; i++) step();
      checks++; if (sd_enable !== 1'b0 || user_idle !== 1'b1) begin errors++; $display("FAIL to_recover: en %b idle %b exp 0 1", sd_enable, user_idle); end
   endtask
   task automatic test_reset_mid_spi;
      int acks = 0;
      spi_req = 1'b1; spi_addr = 32'h44;
      step();
      checks++; if (sd_enable !== 1'b1 || owner_spi !== 1'b1) begin errors++; $display("FAIL rm_granted: en %b owner %b exp 1 1", sd_enable, owner_spi); end
      reset = 1'b1;
      #1;
      checks++; if (sd_enable !== 1'b0) begin errors++; $display("FAIL rm_async_drop: got %b exp 0", sd_enable); end
      checks++; if ({owner_spi, sd_we, sd_wr_mask, spi_ack} !== 5'b0 || sd_addr !== '0 || sd_wr_data !== '0 || rd_data !== '0 || timeout_count !== 8'd0) begin errors++; $display("FAIL rm_reset_vals: owner %b addr %h wd %h rd %h tcnt %0d exp all 0", owner_spi, sd_addr, sd_wr_data, rd_data, timeout_count); end
      spi_req = 1'b0; sd_ack_level = 1'b1; sd_rd_data = 16'h7777;
      #3;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin step(); acks += int'(spi_ack) + int'(sd_enable); end
      checks++; if (acks != 0) begin errors++; $display("FAIL rm_no_ack: got %0d ack/enable events exp 0", acks); end
      sd_ack_level = 1'b0;
      step();
   endtask
   initial begin
      test_reset();
      test_user_write();
      test_spi_priority();
      test_critical_mid_user();
      test_timeout();
      test_reset_mid_spi();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 32, SDRAM logical word address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 16, SDRAM data width.
REQ-003 The module SHALL have parameter TIMEOUT, default 255, maximum cycles from grant to controller ack.
REQ-004 The module SHALL have these ports:
- clk  in  1  system clock (132 MHz).
- reset  in  1  asynchronous, active-high.
- spi_critical  in  1  SPI owns the SDRAM; user accesses are locked out.
- spi_refresh_inhibit  in  1  SPI request to suppress refresh.
- spi_req  in  1  SPI read request; level, held until spi_ack.
- spi_addr  in  ADDR_WIDTH  SPI read address.
- spi_ack  out  1  one-cycle SPI completion pulse.
- user_req  in  1  user request; level, held until user_ack.
- user_we  in  1  user write enable.
- user_addr  in  ADDR_WIDTH  user address.
- user_wr_data  in  DATA_WIDTH  user write data.
- user_wr_mask  in  2  user byte mask.
- user_ack  out  1  one-cycle user completion pulse.
- user_idle  out  1  controller idle, gated for user.
- rd_data  out  DATA_WIDTH  registered read data for the acked requester.
- sd_enable  out  1  controller acc_i.
- sd_we  out  1  controller we_i.
- sd_addr  out  ADDR_WIDTH  controller adr_i.
- sd_wr_data  out  DATA_WIDTH  controller dat_i.
- sd_wr_mask  out  2  controller sel_i.
- sd_rd_data  in  DATA_WIDTH  controller dat_o.
- sd_ack_level  in  1  controller ack_o; level.
- sd_idle  in  1  controller idle_o.
- sd_refresh_inhibit  out  1  controller refresh_inhibit_i.
- owner_spi  out  1  current or last grant went to SPI.
- timeout_count  out  8  saturating count of watchdog expiries.

Function
REQ-005 The FSM SHALL have states IDLE, SPI_ACC, USER_ACC, RELEASE.
REQ-006 In IDLE with spi_req=1, the FSM SHALL go to SPI_ACC regardless of user_req.
REQ-007 In IDLE with spi_req=0, user_req=1 and spi_critical=0, the FSM SHALL go to USER_ACC.
REQ-008 While spi_critical=1, the module SHALL never grant user_req from IDLE.
REQ-009 On grant, the module SHALL latch the address, data, mask and we of the winner into the sd_* registers and assert sd_enable the next cycle.
REQ-010 An SPI grant SHALL drive sd_we=0, sd_wr_mask=2'b00 and sd_wr_data=16'hDEAD.
REQ-011 In SPI_ACC or USER_ACC, on the first cycle that sd_ack_level=1:
- clear sd_enable;
- register sd_rd_data into rd_data;
- pulse the owner's ack for exactly one cycle, on the following cycle;
- go to RELEASE.
REQ-012 In RELEASE, the FSM SHALL wait for sd_ack_level=0, then return to IDLE; a level ack SHALL never produce a second ack pulse.
REQ-013 Latency: req seen in IDLE at cycle N gives sd_enable at N+1; sd_ack_level rising at M gives the owner ack at M+1.
REQ-014 An in-flight USER_ACC SHALL complete even if spi_critical rises mid-access; a pending spi_req SHALL be granted from the next IDLE, ahead of any user request.
REQ-015 A watchdog counter SHALL load 0 on grant and increment each cycle in SPI_ACC or USER_ACC.
REQ-016 When the watchdog reaches TIMEOUT, the module SHALL:
- drop sd_enable;
- increment timeout_count, saturating at 255;
- pulse no ack;
- go to RELEASE.
REQ-017 user_idle SHALL equal sd_idle && !spi_critical && state==IDLE.
REQ-018 sd_refresh_inhibit SHALL be registered as spi_critical && spi_refresh_inhibit, one cycle of latency.
REQ-019 owner_spi SHALL update on each grant and hold between grants.
REQ-020 If spi_req and user_req are sampled together in IDLE, SPI SHALL win and user_req SHALL remain pending.

Reset
REQ-021 Reset SHALL force state IDLE and clear the watchdog.
REQ-022 Reset SHALL drive all these outputs to 0: sd_enable, sd_we, sd_wr_mask, sd_addr, sd_wr_data, acks, rd_data, owner_spi, timeout_count, sd_refresh_inhibit.
REQ-023 Reset asserted mid-access SHALL drop sd_enable asynchronously and produce no ack after release.

Verification
REQ-024 User write of addr 0x100, data 0x1234, mask 2'b11, ack held 3 cycles -> sd_we=1 with matching sd_addr/data; exactly one user_ack; state returns to IDLE.
REQ-025 spi_req and user_req in the same cycle, spi_critical=1 -> SPI served first with sd_we=0 and sd_wr_data=0xDEAD; the user request is not served while critical stays high.
REQ-026 spi_critical rises during USER_ACC -> user_ack still fires; a queued SPI read at 0x10 is granted on the next IDLE cycle.
REQ-027 SPI read with sd_rd_data=0x00A5 -> rd_data=0x00A5 and spi_ack at ack_level+1, with no spi_ack repeat while the level stays high.
REQ-028 sd_ack_level never asserted -> sd_enable drops after TIMEOUT cycles, timeout_count=1, no ack; after 300 such expiries timeout_count=255.
REQ-029 Reset pulsed in SPI_ACC -> sd_enable=0 immediately; outputs at reset values; no spi_ack afterwards.
